slave_cfg_ack_scheduler: RTL
============================

Name: slave_cfg_ack_scheduler

Overview:
- Collects the single-cycle completion and error pulses produced by the slave configuration parser and queues each as a pending acknowledgement.
- Arbitrates the pending acknowledgements round-robin onto the shared USB-CDC TX byte stream, one 6-byte frame at a time, using a valid/ready handshake.
- Frame format matches the host protocol: A5, MODULE, CMD, STATUS, CHK, 5A.

Parameters:
GAP_CYCLES, 0, idle cycles inserted after each frame before the next grant (0..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
evt_spi_mode  input  1  pulse: SPI mode configured (event 0)
evt_i2c_7b_addr  input  1  pulse: I2C 7-bit address configured (event 1)
evt_i2c_reg_size  input  1  pulse: I2C register size configured (event 2)
evt_i2c_mode  input  1  pulse: I2C 7/10-bit mode configured (event 3)
evt_i2c_10b_addr  input  1  pulse: I2C 10-bit address configured (event 4)
evt_parse_error  input  1  pulse: frame/checksum error (event 5)
tx_data  output  8  byte to CDC TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  CDC TX accepts byte
busy  output  1  frame in progress or gap running
pending  output  6  current pending bits, bit i = event i
dropped_count  output  8  saturating count of dropped events

Behaviour:
- Reset: clk and rst_n are the clock and reset; rst_n is asynchronous and active-low. On reset: tx_data=00, tx_valid=0, busy=0, pending=0, dropped_count=0, RR pointer=5 (event 0 searched first), FSM=IDLE. Reset asserted mid-frame aborts the frame immediately; no resume after release.
- Event mapping (MODULE, CMD, STATUS):
  - ev0 01,01,00
  - ev1 02,02,00
  - ev2 02,03,00
  - ev3 02,04,00
  - ev4 02,06,00
  - ev5 FF,FF,EE
  - CHK = MODULE ^ CMD ^ STATUS.
- Pending capture: an event pulse sets its pending bit at the next clock edge. If the bit is already set and is not being granted in that cycle: pending is unchanged and dropped_count increments, saturating at 255. Simultaneous pulses on several events are all captured independently.
- Grant/clear collision: if an event is granted in the same cycle its pulse arrives, set wins. The bit stays 1, no drop is counted, and a second frame follows later.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If pending != 0, grant the first set bit searching from ptr+1 upward, wrapping 5->0.
  - Clear that bit, set ptr=granted index, latch MODULE/CMD/STATUS, byte index=0, go to SEND.
  - tx_valid rises the cycle after the grant.
- SEND:
  - tx_valid=1 and tx_data = byte[index] (A5, MOD, CMD, STATUS, CHK, 5A).
  - Advance only on tx_valid && tx_ready.
  - tx_data is held stable and tx_valid never drops while stalled.
  - After byte 5 is accepted: tx_valid=0 next cycle; go to GAP if GAP_CYCLES>0, else IDLE.
  - There are no back-to-back frames without at least one IDLE cycle.
- GAP: count GAP_CYCLES cycles with tx_valid=0, then go to IDLE.
- Latency: pulse at cycle n; pending visible n+1; grant at end of n+1; A5 presented at n+2 if the scheduler is IDLE.
- Frame duration: 6 cycles minimum with tx_ready held high.
- busy = (state != IDLE).
- Events arriving during SEND or GAP are queued; they are not lost unless duplicated.

Test Plan:
- Single ev0 pulse, tx_ready=1 -> bytes A5 01 01 00 00 5A on 6 consecutive cycles, A5 appearing 2 cycles after the pulse; busy then 0, pending=0.
- ev5 pulse with tx_ready toggling 1/0 each cycle -> A5 FF FF EE EE 5A; tx_data/tx_valid stable during stalls; no byte skipped or repeated.
- ev1, ev2, ev3 pulsed in the same cycle, RR pointer at reset -> frames in order ev1 (CHK 00), ev2 (CHK 01), ev3 (CHK 06). Then pulse ev0 and ev4 together -> ev4 (CHK 04) then ev0 (ptr was 3).
- ev2 pulsed twice while ev0 frame in flight -> one ev2 frame only, dropped_count=1. Repeat 300 duplicate drops -> dropped_count saturates at 255.
- ev3 pulse coincident with its own grant cycle -> two ev3 frames sent, dropped_count unchanged.
- GAP_CYCLES=4: two events queued -> exactly 4 cycles tx_valid=0 plus 1 IDLE cycle between 5A and the next A5. Reset asserted at byte 2 -> tx_valid=0 immediately, pending=0, no frame after release.

Source files
------------

// File: rtl/slave_cfg_ack_scheduler.sv
// slave_cfg_ack_scheduler
// Queues single-cycle completion/error pulses from the slave configuration
// parser as pending acknowledgements. Each acknowledgement goes out as one
// 6-byte frame (A5, MODULE, CMD, STATUS, CHK, 5A) on the shared CDC TX byte
// stream. Pending acknowledgements are served round-robin.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   evt_*              event pulses 0..5 (see event table below)
//   tx_data/tx_valid   byte stream towards CDC TX, held stable while stalled
//   tx_ready           CDC TX accepts the current byte
//   busy               frame in progress or inter-frame gap running
//   pending            pending acknowledgement bits, bit i = event i
//   dropped_count      saturating count of duplicate events that were dropped
module slave_cfg_ack_scheduler #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       evt_spi_mode,
  input  logic       evt_i2c_7b_addr,
  input  logic       evt_i2c_reg_size,
  input  logic       evt_i2c_mode,
  input  logic       evt_i2c_10b_addr,
  input  logic       evt_parse_error,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [5:0] pending,
  output logic [7:0] dropped_count
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e     state_q, state_d;
  logic [5:0] evt;
  logic [5:0] pending_q, pending_d;
  logic [5:0] grant_mask, drop_mask;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] cand;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic [7:0] mod_q, mod_d, cmd_q, cmd_d, sts_q, sts_d;
  logic [7:0] ev_mod, ev_cmd, ev_sts;
  logic [7:0] gap_q, gap_d;
  logic [7:0] dropped_q, dropped_d;
  logic [3:0] drop_num;
  logic [8:0] drop_sum;

  assign evt = {evt_parse_error, evt_i2c_10b_addr, evt_i2c_mode,
                evt_i2c_reg_size, evt_i2c_7b_addr, evt_spi_mode};

  // Round-robin search: first set bit starting at ptr+1, wrapping 5 -> 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= 6; k++) begin
      cand = 3'((32'(ptr_q) + k) % 32'd6);
      if (!grant_vld && pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Frame contents for the candidate grant.
  always_comb begin
    ev_mod = 8'h00;
    ev_cmd = 8'h00;
    ev_sts = 8'h00;
    unique case (grant_idx)
      3'd0:    begin ev_mod = 8'h01; ev_cmd = 8'h01; ev_sts = 8'h00; end
      3'd1:    begin ev_mod = 8'h02; ev_cmd = 8'h02; ev_sts = 8'h00; end
      3'd2:    begin ev_mod = 8'h02; ev_cmd = 8'h03; ev_sts = 8'h00; end
      3'd3:    begin ev_mod = 8'h02; ev_cmd = 8'h04; ev_sts = 8'h00; end
      3'd4:    begin ev_mod = 8'h02; ev_cmd = 8'h06; ev_sts = 8'h00; end
      3'd5:    begin ev_mod = 8'hFF; ev_cmd = 8'hFF; ev_sts = 8'hEE; end
      default: begin ev_mod = 8'h00; ev_cmd = 8'h00; ev_sts = 8'h00; end
    endcase
  end

  // Pending capture: a new pulse always wins over a same-cycle grant clear;
  // a pulse on a bit that stays set is a dropped duplicate.
  always_comb begin
    grant_mask = '0;
    if (state_q == StIdle && grant_vld) begin
      grant_mask = 6'b000001 << grant_idx;
    end
    drop_mask = evt & pending_q & ~grant_mask;
    pending_d = (pending_q & ~grant_mask) | evt;
    drop_num  = '0;
    for (int i = 0; i < 6; i++) begin
      drop_num = drop_num + {3'b000, drop_mask[i]};
    end
    drop_sum  = {1'b0, dropped_q} + {5'b00000, drop_num};
    dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    mod_d   = mod_q;
    cmd_d   = cmd_q;
    sts_d   = sts_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          state_d = StSend;
          ptr_d   = grant_idx;
          idx_d   = '0;
          mod_d   = ev_mod;
          cmd_d   = ev_cmd;
          sts_d   = ev_sts;
        end
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == 3'd5) begin
            if (GAP_CYCLES != 0) begin
              state_d = StGap;
              gap_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StGap: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      ptr_q     <= 3'd5;
      idx_q     <= '0;
      mod_q     <= '0;
      cmd_q     <= '0;
      sts_q     <= '0;
      gap_q     <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      mod_q     <= mod_d;
      cmd_q     <= cmd_d;
      sts_q     <= sts_d;
      gap_q     <= gap_d;
      dropped_q <= dropped_d;
    end
  end

  // Outputs.
  always_comb begin
    tx_valid = (state_q == StSend);
    busy     = (state_q != StIdle);
    tx_data  = 8'h00;
    if (state_q == StSend) begin
      unique case (idx_q)
        3'd0:    tx_data = 8'hA5;
        3'd1:    tx_data = mod_q;
        3'd2:    tx_data = cmd_q;
        3'd3:    tx_data = sts_q;
        3'd4:    tx_data = mod_q ^ cmd_q ^ sts_q;
        3'd5:    tx_data = 8'h5A;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign pending       = pending_q;
  assign dropped_count = dropped_q;

endmodule
